// File: rtl/ritc_pkg.sv
// Shared encoding for the RITC delay-load sequencer: register-bus word layout,
// table geometry and the {ch,tap} -> table slot mapping.
package ritc_pkg;

  localparam int DAT_VAL_LSB   = 0;
  localparam int DAT_TAP_LSB   = 5;
  localparam int DAT_CH_LSB    = 9;

  localparam int NUM_CH        = 6;
  localparam int NUM_DATA_TAPS = 12;
  localparam int TAPS_PER_CH   = NUM_DATA_TAPS + 1;
  localparam int TBL_DEPTH     = NUM_CH * TAPS_PER_CH;

  // Tap 15 addresses the clock-path delay element
  localparam logic [3:0]  CLK_TAP       = 4'd15;
  localparam logic [31:0] CTRL_RST_WORD = 32'h0000_0001;

  typedef enum logic {
    REG_DELAY = 1'b0,
    REG_CTRL  = 1'b1
  } user_reg_e;

  function automatic logic tbl_valid(input logic [2:0] ch, input logic [3:0] tap);
    return (ch < 3'(NUM_CH)) && ((tap < 4'(NUM_DATA_TAPS)) || (tap == CLK_TAP));
  endfunction

  // Clock tap occupies the slot right after the last data tap of its channel
  function automatic logic [6:0] tbl_index(input logic [2:0] ch, input logic [3:0] tap);
    logic [6:0] tap_slot;
    tap_slot = (tap == CLK_TAP) ? 7'(NUM_DATA_TAPS) : {3'b000, tap};
    return 7'(ch) * 7'(TAPS_PER_CH) + tap_slot;
  endfunction

  function automatic logic [31:0] pack_delay_word(input logic [2:0] ch, input logic [3:0] tap,
                                                  input logic [4:0] val);
    logic [31:0] word;
    word                    = '0;
    word[DAT_VAL_LSB +: 5]  = val;
    word[DAT_TAP_LSB +: 4]  = tap;
    word[DAT_CH_LSB  +: 3]  = ch;
    return word;
  endfunction

endpackage

// File: rtl/ritc_delay_sequencer_if.sv
// Register-bus write port driven by the delay sequencer.
interface ritc_delay_sequencer_if;
  logic        user_sel_o;
  logic        user_wr_o;
  logic        user_addr_o;
  logic [31:0] user_dat_o;

  modport master (output user_sel_o, output user_wr_o, output user_addr_o, output user_dat_o);
  modport slave  (input  user_sel_o, input  user_wr_o, input  user_addr_o, input  user_dat_o);
endinterface

// File: rtl/ritc_delay_table.sv
// 78 x 5-bit tap-delay table: synchronous write, combinational read, cleared by reset.
module ritc_delay_table
  import ritc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [4:0] wr_dat,
  input  logic [6:0] rd_addr,
  output logic [4:0] rd_dat
);

  logic [4:0] mem_reg [TBL_DEPTH];
  logic       wr_ok;
  logic       rd_ok;
  logic [6:0] wr_idx;
  logic [6:0] rd_idx;

  // Holes in the {ch,tap} space (taps 12..14, ch 6..7) never reach the array
  assign wr_ok  = wr_en && tbl_valid(wr_addr[6:4], wr_addr[3:0]);
  assign wr_idx = tbl_index(wr_addr[6:4], wr_addr[3:0]);
  assign rd_ok  = tbl_valid(rd_addr[6:4], rd_addr[3:0]);
  assign rd_idx = tbl_index(rd_addr[6:4], rd_addr[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_reg[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = rd_ok ? mem_reg[rd_idx] : '0;

endmodule

// File: rtl/ritc_delay_sequencer.sv
// Walks the delay table and issues one register write per tap, optionally
// preceded by an IDELAYCTRL reset write and settle wait.
module ritc_delay_sequencer
  import ritc_pkg::*;
#(
  parameter int GAP_CYCLES      = 4,
  parameter int RST_WAIT_CYCLES = 64
)(
  input  logic                          user_clk_i,
  input  logic                          user_rst_n_i,
  input  logic                          tbl_wr_i,
  input  logic [6:0]                    tbl_addr_i,
  input  logic [4:0]                    tbl_dat_i,
  input  logic                          start_i,
  input  logic                          ctrl_rst_i,
  output logic                          busy_o,
  output logic                          done_o,
  ritc_delay_sequencer_if.master        bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_WR   = 3'd1;
  localparam logic [2:0] ST_RST_WAIT = 3'd2;
  localparam logic [2:0] ST_LD_WR    = 3'd3;
  localparam logic [2:0] ST_LD_GAP   = 3'd4;
  localparam logic [2:0] ST_FIN      = 3'd5;

  logic [2:0]  state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [2:0]  ch_reg, ch_next;
  logic [3:0]  tap_reg, tap_next;
  logic        busy_reg, done_reg, sel_reg, addr_reg;
  logic [31:0] dat_reg, dat_next;
  logic [4:0]  tbl_rd_dat;

  ritc_delay_table u_table (
    .clk     (user_clk_i),
    .rst_n   (user_rst_n_i),
    .wr_en   (tbl_wr_i & ~busy_reg),
    .wr_addr (tbl_addr_i),
    .wr_dat  (tbl_dat_i),
    .rd_addr ({ch_reg, tap_reg}),
    .rd_dat  (tbl_rd_dat)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ch_next    = ch_reg;
    tap_next   = tap_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        ch_next  = '0;
        tap_next = '0;
        if (start_i) state_next = ctrl_rst_i ? ST_RST_WR : ST_LD_WR;
      end
      ST_RST_WR: begin
        state_next = ST_RST_WAIT;
        cnt_next   = 8'(RST_WAIT_CYCLES - 1);
      end
      ST_RST_WAIT: begin
        if (cnt_reg == '0) state_next = ST_LD_WR;
        else               cnt_next   = cnt_reg - 8'd1;
      end
      // Pointer advances as the write issues, so it already names the next tap
      ST_LD_WR: begin
        state_next = ST_LD_GAP;
        cnt_next   = 8'(GAP_CYCLES - 2);
        if (tap_reg == CLK_TAP) begin
          tap_next = '0;
          ch_next  = ch_reg + 3'd1;
        end else if (tap_reg == 4'(NUM_DATA_TAPS - 1)) begin
          tap_next = CLK_TAP;
        end else begin
          tap_next = tap_reg + 4'd1;
        end
      end
      ST_LD_GAP: begin
        if (cnt_reg == '0) state_next = (ch_reg == 3'(NUM_CH)) ? ST_FIN : ST_LD_WR;
        else               cnt_next   = cnt_reg - 8'd1;
      end
      ST_FIN: begin
        state_next = ST_IDLE;
        ch_next    = '0;
        tap_next   = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus word is built from the state being entered so outputs leave a flop
  always_comb begin
    dat_next = '0;
    if (state_next == ST_RST_WR)     dat_next = CTRL_RST_WORD;
    else if (state_next == ST_LD_WR) dat_next = pack_delay_word(ch_reg, tap_reg, tbl_rd_dat);
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ch_reg    <= '0;
      tap_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sel_reg   <= 1'b0;
      addr_reg  <= 1'b0;
      dat_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ch_reg    <= ch_next;
      tap_reg   <= tap_next;
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= (state_next == ST_FIN);
      sel_reg   <= (state_next == ST_RST_WR) || (state_next == ST_LD_WR);
      addr_reg  <= (state_next == ST_RST_WR) ? REG_CTRL : REG_DELAY;
      dat_reg   <= dat_next;
    end
  end

  assign busy_o          = busy_reg;
  assign done_o          = done_reg;
  assign bus.user_sel_o  = sel_reg;
  assign bus.user_wr_o   = sel_reg;
  assign bus.user_addr_o = addr_reg;
  assign bus.user_dat_o  = dat_reg;

endmodule

// File: tb/tb_ritc_delay_sequencer.sv
// Randomized-table bench for ritc_delay_sequencer against a list-based model of the write stream.
module tb_ritc_delay_sequencer;

  logic       user_clk_i = 1'b0;
  logic       user_rst_n_i;
  logic       tbl_wr_i;
  logic [6:0] tbl_addr_i;
  logic [4:0] tbl_dat_i;
  logic       start_i;
  logic       ctrl_rst_i;
  logic       busy_o;
  logic       done_o;

  ritc_delay_sequencer_if bus_if ();

  ritc_delay_sequencer #(.GAP_CYCLES(4), .RST_WAIT_CYCLES(64)) dut (
    .user_clk_i   (user_clk_i),
    .user_rst_n_i (user_rst_n_i),
    .tbl_wr_i     (tbl_wr_i),
    .tbl_addr_i   (tbl_addr_i),
    .tbl_dat_i    (tbl_dat_i),
    .start_i      (start_i),
    .ctrl_rst_i   (ctrl_rst_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bus          (bus_if)
  );

  always #5 user_clk_i = ~user_clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [4:0]  model_tbl [8][16];
  logic [31:0] last_wr_dat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit idx_ok(input int ch, input int tap);
    return (ch < 6) && ((tap < 12) || (tap == 15));
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 8; c++)
      for (int t = 0; t < 16; t++)
        model_tbl[c][t] = '0;
  endtask

  task automatic tbl_write(input int ch, input int tap, input logic [4:0] val);
    @(negedge user_clk_i);
    tbl_wr_i   = 1'b1;
    tbl_addr_i = 7'((ch << 4) | tap);
    tbl_dat_i  = val;
    @(negedge user_clk_i);
    tbl_wr_i   = 1'b0;
    if (idx_ok(ch, tap)) model_tbl[ch][tap] = val;
  endtask

  // Start a sequence and compare the observed write stream with the ideal one
  task automatic run_and_check(input bit use_rst, input bit inject, input bit release_rst,
                               input string name);
    int          wr_n [$];
    logic        wr_a [$];
    logic [31:0] wr_d [$];
    int          ex_n [$];
    logic        ex_a [$];
    logic [31:0] ex_d [$];
    int          done_n = -1;
    int          glitch = 0;
    int          busy_low = 0;
    int          base;
    int          tap;
    int          cnt;

    @(negedge user_clk_i);
    if (release_rst) user_rst_n_i = 1'b1;
    start_i    = 1'b1;
    ctrl_rst_i = use_rst;
    @(negedge user_clk_i);
    start_i    = 1'b0;
    ctrl_rst_i = 1'b0;
    for (int n = 0; n < 700 && done_n < 0; n++) begin
      if (n > 0) @(negedge user_clk_i);
      if (inject && n == 20) begin
        start_i    = 1'b1;
        tbl_wr_i   = 1'b1;
        tbl_addr_i = 7'((4 << 4) | 5);
        tbl_dat_i  = 5'h1F;
      end else if (inject && n == 21) begin
        start_i  = 1'b0;
        tbl_wr_i = 1'b0;
      end
      if (bus_if.user_wr_o === 1'b1) begin
        wr_n.push_back(n);
        wr_a.push_back(bus_if.user_addr_o);
        wr_d.push_back(bus_if.user_dat_o);
        if (bus_if.user_sel_o !== 1'b1) glitch++;
      end else if (bus_if.user_sel_o !== 1'b0 || bus_if.user_addr_o !== 1'b0 ||
                   bus_if.user_dat_o !== 32'h0) begin
        glitch++;
      end
      if (busy_o !== 1'b1) busy_low++;
      if (done_o === 1'b1) done_n = n;
    end

    base = use_rst ? 65 : 0;
    if (use_rst) begin
      ex_n.push_back(0); ex_a.push_back(1'b1); ex_d.push_back(32'h1);
    end
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      for (int t = 0; t < 13; t++) begin
        tap = (t < 12) ? t : 15;
        ex_n.push_back(base + 4 * cnt);
        ex_a.push_back(1'b0);
        ex_d.push_back(32'(model_tbl[c][tap]) + 32'(tap << 5) + 32'(c << 9));
        cnt++;
      end
    end

    check({name, "_done_cycle"}, 32'(done_n), 32'(base + 312));
    check({name, "_busy_during"}, 32'(busy_low), 32'd0);
    check({name, "_bus_idle_zero"}, 32'(glitch), 32'd0);
    check({name, "_write_count"}, 32'(wr_n.size()), 32'(ex_n.size()));
    for (int i = 0; i < wr_n.size() && i < ex_n.size(); i++) begin
      $display("%s write %0d: cycle=%0d addr=%0d dat=0x%03h (model cycle=%0d addr=%0d dat=0x%03h)",
               name, i, wr_n[i], wr_a[i], wr_d[i], ex_n[i], ex_a[i], ex_d[i]);
      check({name, "_wr_cycle"}, 32'(wr_n[i]), 32'(ex_n[i]));
      check({name, "_wr_addr"}, 32'(wr_a[i]), 32'(ex_a[i]));
      check({name, "_wr_dat"}, wr_d[i], ex_d[i]);
    end
    @(negedge user_clk_i);
    check({name, "_busy_after_done"}, 32'(busy_o), 32'd0);
    check({name, "_done_one_cycle"}, 32'(done_o), 32'd0);
    last_wr_dat = wr_d;
  endtask

  initial begin
    int nwr;
    user_rst_n_i = 1'b0;
    tbl_wr_i     = 1'b0;
    tbl_addr_i   = '0;
    tbl_dat_i    = '0;
    start_i      = 1'b0;
    ctrl_rst_i   = 1'b0;
    model_clear();

    repeat (3) @(negedge user_clk_i);
    check("reset_busy_done", 32'({busy_o, done_o}), 32'd0);
    check("reset_bus_ctl", 32'({bus_if.user_sel_o, bus_if.user_wr_o, bus_if.user_addr_o}), 32'd0);
    check("reset_bus_dat", bus_if.user_dat_o, 32'h0);

    // Start on the very first edge after reset release, all-zero table
    run_and_check(1'b0, 1'b0, 1'b1, "run_zero");

    for (int a = 0; a < 128; a++) tbl_write(a >> 4, a & 15, 5'($urandom_range(0, 31)));
    tbl_write(2, 7, 5'h13);
    tbl_write(5, 15, 5'($urandom_range(1, 31)));
    tbl_write(1, 13, 5'h1F);
    tbl_write(6, 0, 5'h1F);
    tbl_write(7, 15, 5'h1F);
    $display("table loaded: ch2 tap7=0x%0h ch5 tap15=0x%0h", model_tbl[2][7], model_tbl[5][15]);

    run_and_check(1'b0, 1'b0, 1'b0, "run_rand");
    check("ch2_tap7_word", (last_wr_dat.size() > 33) ? last_wr_dat[33] : 32'hDEAD_BEEF, 32'h4F3);
    check("last_word", (last_wr_dat.size() == 78) ? last_wr_dat[77] : 32'hDEAD_BEEF,
          32'hBE0 | 32'(model_tbl[5][15]));

    // Control-reset prefix, with a restart request and table write while busy
    run_and_check(1'b1, 1'b1, 1'b0, "run_ctrl_rst");
    run_and_check(1'b0, 1'b0, 1'b0, "run_recheck");

    // Abort mid-sequence while the 11th write is on the bus
    @(negedge user_clk_i);
    start_i = 1'b1;
    @(negedge user_clk_i);
    start_i = 1'b0;
    nwr = 0;
    for (int n = 0; n < 200 && nwr < 11; n++) begin
      if (n > 0) @(negedge user_clk_i);
      if (bus_if.user_wr_o === 1'b1) nwr++;
    end
    check("abort_write_live", 32'(bus_if.user_wr_o), 32'd1);
    user_rst_n_i = 1'b0;
    #1;
    check("abort_ctl_zero", 32'({bus_if.user_sel_o, bus_if.user_wr_o, bus_if.user_addr_o,
                                 busy_o, done_o}), 32'd0);
    check("abort_dat_zero", bus_if.user_dat_o, 32'h0);
    $display("reset asserted after write %0d", nwr);
    repeat (3) begin
      @(negedge user_clk_i);
      check("abort_held_zero", 32'({bus_if.user_wr_o, busy_o}), 32'd0);
    end
    @(negedge user_clk_i);
    user_rst_n_i = 1'b1;
    model_clear();
    repeat (4) begin
      @(negedge user_clk_i);
      check("post_reset_idle", 32'({bus_if.user_wr_o, busy_o, done_o}), 32'd0);
    end
    run_and_check(1'b0, 1'b0, 1'b0, "run_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
